// File: rtl/rom_access_ctrl_if.sv
// rom_access_ctrl_if: ROM strobe side and SDRAM request side of rom_access_ctrl
// slave modport: the access engine (takes ROM strobes and MEM_ACK/MEM_DOUT, drives ROM_Q, MEM_* and BUSY).
// master modport: the environment around it (mapper mux plus SDRAM controller).
interface rom_access_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [15:0]       ROM_D;
  logic              ROM_CE_N;
  logic              ROM_OE_N;
  logic              ROM_WE_N;
  logic              ROM_WORD;
  logic [15:0]       ROM_Q;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [15:0]       MEM_DIN;
  logic [1:0]        MEM_BE;
  logic              MEM_ACK;
  logic [15:0]       MEM_DOUT;
  logic              BUSY;
  modport slave (
    input  ROM_ADDR, ROM_D, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_WORD, MEM_ACK, MEM_DOUT,
    output ROM_Q, MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN, MEM_BE, BUSY
  );
  modport master (
    output ROM_ADDR, ROM_D, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_WORD, MEM_ACK, MEM_DOUT,
    input  ROM_Q, MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN, MEM_BE, BUSY
  );
endinterface

// File: rtl/rom_access_ctrl.sv
// rom_access_ctrl: turns muxed cartridge ROM strobes into single-outstanding SDRAM requests
// Ports: MCLK system clock (rising edge), RESET_N asynchronous active-low reset,
// bus (slave modport): ROM_* strobes/data in, ROM_Q read data out, MEM_* request/handshake, BUSY.
// Optional: define ROM_READ_CACHE_EN for a one-entry read cache (hit in IDLE answers without MEM_REQ).
module rom_access_ctrl #(
  parameter int ADDR_W = 24
) (
  input logic              MCLK,
  input logic              RESET_N,
  rom_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state_q, state_d;
  logic rd, wr, rd_trig, wr_trig, trig, hit;
  logic [15:0] cap_din, hit_data;
  logic [1:0] cap_be;
  logic rd_q, rd_d, wr_q, wr_d, last_word_q, last_word_d;
  logic [ADDR_W-1:1] last_addr_q, last_addr_d, pend_addr_q, pend_addr_d, mem_addr_q, mem_addr_d;
  logic pend_valid_q, pend_valid_d, pend_we_q, pend_we_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [15:0] pend_din_q, pend_din_d, mem_din_q, mem_din_d, rom_q_q, rom_q_d;
  logic [1:0] pend_be_q, pend_be_d, mem_be_q, mem_be_d;

  // Byte enables double as the access descriptor: 11 = word, 10 = odd byte, 01 = even byte.
  function automatic logic [15:0] fmt(input logic [1:0] be, input logic [15:0] d);
    return &be ? d : {d[15:8], be[1] ? d[15:8] : d[7:0]};
  endfunction

  assign rd      = ~bus.ROM_CE_N & ~bus.ROM_OE_N;
  assign wr      = ~bus.ROM_CE_N & ~bus.ROM_WE_N;
  assign wr_trig = wr & ~wr_q;
  // A held read strobe retriggers when the mapper moves to another word or changes access width.
  assign rd_trig = rd & ~wr & (~rd_q | bus.ROM_ADDR[ADDR_W-1:1] != last_addr_q | bus.ROM_WORD != last_word_q);
  assign trig    = rd_trig | wr_trig;
  assign cap_be  = bus.ROM_WORD ? 2'b11 : bus.ROM_ADDR[0] ? 2'b10 : 2'b01;
  assign cap_din = bus.ROM_WORD ? bus.ROM_D : {2{bus.ROM_D[7:0]}};

  assign bus.ROM_Q    = rom_q_q;
  assign bus.MEM_REQ  = mem_req_q;
  assign bus.MEM_WE   = mem_we_q;
  assign bus.MEM_ADDR = {mem_addr_q, 1'b0};
  assign bus.MEM_DIN  = mem_din_q;
  assign bus.MEM_BE   = mem_be_q;
  assign bus.BUSY     = state_q != IDLE || pend_valid_q;

`ifdef ROM_READ_CACHE_EN
  logic c_valid_q, c_valid_d;
  logic [ADDR_W-1:1] c_tag_q, c_tag_d;
  logic [15:0] c_data_q, c_data_d;
  assign hit      = c_valid_q && c_tag_q == bus.ROM_ADDR[ADDR_W-1:1];
  assign hit_data = c_data_q;
  always_comb begin
    c_valid_d = c_valid_q;
    c_tag_d   = c_tag_q;
    c_data_d  = c_data_q;
    if (state_q == REQ && bus.MEM_ACK && !mem_we_q) begin
      c_valid_d = 1'b1;
      c_tag_d   = mem_addr_q;
      c_data_d  = bus.MEM_DOUT;
    end
    // Invalidate at the write strobe and again when the write is issued, so a read
    // completing between the two cannot leave pre-write data cached.
    if (wr_trig && bus.ROM_ADDR[ADDR_W-1:1] == c_tag_d) c_valid_d = 1'b0;
    if (mem_req_d && !mem_req_q && mem_we_d && mem_addr_d == c_tag_d) c_valid_d = 1'b0;
  end
  always_ff @(posedge MCLK or negedge RESET_N)
    if (!RESET_N) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_data_q  <= '0;
    end else begin
      c_valid_q <= c_valid_d;
      c_tag_q   <= c_tag_d;
      c_data_q  <= c_data_d;
    end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    rd_d         = rd;
    wr_d         = wr;
    last_addr_d  = rd ? bus.ROM_ADDR[ADDR_W-1:1] : last_addr_q;
    last_word_d  = rd ? bus.ROM_WORD : last_word_q;
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_din_d   = pend_din_q;
    pend_be_d    = pend_be_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_be_d     = mem_be_q;
    rom_q_d      = rom_q_q;
    case (state_q)
      IDLE:
        if (pend_valid_q) begin
          state_d      = REQ;
          mem_req_d    = 1'b1;
          mem_we_d     = pend_we_q;
          mem_addr_d   = pend_addr_q;
          mem_din_d    = pend_din_q;
          mem_be_d     = pend_be_q;
          // The slot empties as it issues, so a simultaneous trigger simply refills it.
          pend_valid_d = trig;
          pend_we_d    = wr_trig;
          pend_addr_d  = bus.ROM_ADDR[ADDR_W-1:1];
          pend_din_d   = cap_din;
          pend_be_d    = cap_be;
        end else if (rd_trig && hit) rom_q_d = fmt(cap_be, hit_data);
        else if (trig) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = wr_trig;
          mem_addr_d = bus.ROM_ADDR[ADDR_W-1:1];
          mem_din_d  = cap_din;
          mem_be_d   = cap_be;
        end
      REQ:
        if (bus.MEM_ACK) begin
          state_d   = GAP;
          mem_req_d = 1'b0;
          if (!mem_we_q) rom_q_d = fmt(mem_be_q, bus.MEM_DOUT);
        end
      default: state_d = IDLE;
    endcase
    // One-deep slot: newer triggers replace a waiting read, but a waiting write is never lost to a read.
    if (state_q != IDLE && trig && !(pend_valid_q && pend_we_q && !wr_trig)) begin
      pend_valid_d = 1'b1;
      pend_we_d    = wr_trig;
      pend_addr_d  = bus.ROM_ADDR[ADDR_W-1:1];
      pend_din_d   = cap_din;
      pend_be_d    = cap_be;
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q      <= IDLE;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      last_addr_q  <= '0;
      last_word_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_din_q   <= '0;
      pend_be_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_be_q     <= '0;
      rom_q_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      last_addr_q  <= last_addr_d;
      last_word_q  <= last_word_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_din_q   <= pend_din_d;
      pend_be_q    <= pend_be_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_be_q     <= mem_be_d;
      rom_q_q      <= rom_q_d;
    end
endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb_rom_access_ctrl: table-driven and scoreboarded checks of rom_access_ctrl
module tb_rom_access_ctrl;
  localparam int ADDR_W = 24;
  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [1:0]  be;
    logic [15:0] din;
  } req_t;
  typedef struct {
    logic        we;
    logic        word;
    logic [23:0] addr;
    logic [15:0] d;
    int          lat;
    logic [15:0] dout;
    logic [23:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_din;
    logic [15:0] e_q;
  } vec_t;

  logic MCLK = 0;
  logic RESET_N = 1;
  int n_vec = 0;
  int n_err = 0;
  int ack_lat = 0;
  int man_req = 0;
  int man_seen = 0;
  int resp_cnt = 0;
  logic [15:0] rsp_data = 0;
  logic mon_prev = 0;
  req_t mon_held, mon_e;
  req_t exp_q[$];
  vec_t vt[9];
  vec_t v;
  logic [15:0] q3;

  rom_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  rom_access_ctrl #(.ADDR_W(ADDR_W)) dut (.MCLK(MCLK), .RESET_N(RESET_N), .bus(bus));

  always #5 MCLK = ~MCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SDRAM model: ACK after ack_lat cycles of MEM_REQ, or a manual stray ACK on request.
  initial begin
    bus.MEM_ACK = 0;
    bus.MEM_DOUT = 0;
    forever begin
      @(negedge MCLK);
      if (bus.MEM_ACK) bus.MEM_ACK = 0;
      else if (man_seen != man_req) begin
        bus.MEM_ACK = 1;
        bus.MEM_DOUT = 16'hDEAD;
        man_seen = man_req;
      end else if (bus.MEM_REQ) begin
        if (resp_cnt >= ack_lat) begin
          bus.MEM_ACK = 1;
          bus.MEM_DOUT = rsp_data;
          resp_cnt = 0;
        end else resp_cnt++;
      end else resp_cnt = 0;
    end
  end

  // Request monitor: each new request pops the scoreboard; fields must hold while MEM_REQ stays high.
  initial forever begin
    @(negedge MCLK);
    if (bus.MEM_REQ && !mon_prev) begin
      mon_held = '{bus.MEM_WE, bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DIN};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got request addr %0h, expected none", bus.MEM_ADDR);
      end else begin
        mon_e = exp_q.pop_front();
        chk("req_we", 32'(bus.MEM_WE), 32'(mon_e.we));
        chk("req_addr", 32'(bus.MEM_ADDR), 32'(mon_e.addr));
        chk("req_be", 32'(bus.MEM_BE), 32'(mon_e.be));
        chk("req_din", 32'(bus.MEM_DIN), 32'(mon_e.din));
      end
    end else if (bus.MEM_REQ) begin
      chk("hold_addr", 32'(bus.MEM_ADDR), 32'(mon_held.addr));
      chk("hold_ctl", 32'({bus.MEM_WE, bus.MEM_BE, bus.MEM_DIN}), 32'({mon_held.we, mon_held.be, mon_held.din}));
    end
    mon_prev = bus.MEM_REQ;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic idle();
    @(negedge MCLK);
    bus.ROM_CE_N = 1;
    bus.ROM_OE_N = 1;
    bus.ROM_WE_N = 1;
    repeat (2) @(negedge MCLK);
  endtask

  task automatic drive(input logic we, input logic word, input logic [23:0] addr, input logic [15:0] d);
    bus.ROM_ADDR = addr;
    bus.ROM_WORD = word;
    bus.ROM_D = d;
    bus.ROM_CE_N = 0;
    bus.ROM_OE_N = we;
    bus.ROM_WE_N = !we;
  endtask

  task automatic apply(input vec_t x);
    int n = 0;
    @(negedge MCLK);
    ack_lat = x.lat;
    rsp_data = x.dout;
    drive(x.we, x.word, x.addr, x.d);
    exp_q.push_back('{x.we, x.e_addr, x.e_be, x.e_din});
    @(negedge MCLK);
    chk("req_at_t1", 32'(bus.MEM_REQ), 1);
    chk("busy_req", 32'(bus.BUSY), 1);
    while (bus.MEM_REQ && n < 30) begin
      @(negedge MCLK);
      n++;
    end
    chk("ack_to_done", n, x.lat + 1);
    chk("rom_q", 32'(bus.ROM_Q), 32'(x.e_q));
    idle();
    chk("busy_idle", 32'(bus.BUSY), 0);
  endtask

  initial begin
    int n;
    vt[0] = '{0, 1, 24'h012344, 0,          2, 16'hBEEF, 24'h012344, 2'b11, 0,          16'hBEEF};
    vt[1] = '{1, 0, 24'h000101, 16'h005A,   1, 16'h0000, 24'h000100, 2'b10, 16'h5A5A,   16'hBEEF};
    vt[2] = '{0, 0, 24'h000201, 0,          0, 16'hA1B2, 24'h000200, 2'b10, 0,          16'hA1A1};
    vt[3] = '{0, 0, 24'h000200, 0,          3, 16'hA1B2, 24'h000200, 2'b01, 0,          16'hA1B2};
    vt[4] = '{1, 1, 24'h000300, 16'hCAFE,   0, 16'hFFFF, 24'h000300, 2'b11, 16'hCAFE,   16'hA1B2};
    vt[5] = '{1, 0, 24'h000300, 16'h1277,   2, 16'hFFFF, 24'h000300, 2'b01, 16'h7777,   16'hA1B2};
    vt[6] = '{0, 1, 24'hFFFFFE, 0,          1, 16'h0F0F, 24'hFFFFFE, 2'b11, 0,          16'h0F0F};
    vt[7] = '{0, 0, 24'h000005, 0,          0, 16'h8001, 24'h000004, 2'b10, 0,          16'h8080};
    vt[8] = '{0, 1, 24'h000011, 0,          1, 16'h5555, 24'h000010, 2'b11, 0,          16'h5555};
    bus.ROM_ADDR = 0;
    bus.ROM_D = 0;
    bus.ROM_WORD = 1;
    bus.ROM_CE_N = 1;
    bus.ROM_OE_N = 1;
    bus.ROM_WE_N = 1;
    #1 RESET_N = 0;
    #12;
    chk("rst_rom_q", 32'(bus.ROM_Q), 0);
    chk("rst_mem_req", 32'(bus.MEM_REQ), 0);
    chk("rst_mem_we", 32'(bus.MEM_WE), 0);
    chk("rst_mem_addr", 32'(bus.MEM_ADDR), 0);
    chk("rst_mem_din", 32'(bus.MEM_DIN), 0);
    chk("rst_mem_be", 32'(bus.MEM_BE), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    @(negedge MCLK);
    RESET_N = 1;
    repeat (2) @(negedge MCLK);

    for (int i = 0; i < 9; i++) apply(vt[i]);

    // Read strobe held while the address walks: one request per new word, none repeated.
    ack_lat = 2;
    for (int k = 0; k < 3; k++) begin
      @(negedge MCLK);
      rsp_data = 16'h1000 + 16'(k);
      drive(0, 1, 24'h000010 + 24'(2 * k), 0);
      exp_q.push_back('{0, 24'h000010 + 24'(2 * k), 2'b11, 0});
      repeat (7) @(negedge MCLK);
      chk("stream_rom_q", 32'(bus.ROM_Q), 32'h1000 + 32'(k));
    end
    idle();
    chk("stream_queue", exp_q.size(), 0);

    // Two read triggers during a long stall: only the newer one is issued after GAP.
    @(negedge MCLK);
    ack_lat = 10;
    rsp_data = 16'h1111;
    drive(0, 1, 24'h000100, 0);
    exp_q.push_back('{0, 24'h000100, 2'b11, 0});
    @(negedge MCLK);
    @(negedge MCLK);
    bus.ROM_ADDR = 24'h000200;
    @(negedge MCLK);
    bus.ROM_ADDR = 24'h000300;
    exp_q.push_back('{0, 24'h000300, 2'b11, 0});
    n = 0;
    while (bus.MEM_REQ && n < 30) begin
      chk("stall_busy", 32'(bus.BUSY), 1);
      @(negedge MCLK);
      n++;
    end
    chk("stall_rom_q1", 32'(bus.ROM_Q), 16'h1111);
    rsp_data = 16'h3333;
    ack_lat = 0;
    n = 0;
    while (!bus.MEM_REQ && n < 5) begin
      chk("gap_busy", 32'(bus.BUSY), 1);
      @(negedge MCLK);
      n++;
    end
    chk("gap_cycles", n, 2);
    n = 0;
    while (bus.MEM_REQ && n < 30) begin
      chk("stall_busy2", 32'(bus.BUSY), 1);
      @(negedge MCLK);
      n++;
    end
    chk("stall_rom_q2", 32'(bus.ROM_Q), 16'h3333);
    idle();
    chk("stall_busy_end", 32'(bus.BUSY), 0);
    chk("stall_queue", exp_q.size(), 0);

    // Reset in the middle of a request, then a stray late ACK.
    @(negedge MCLK);
    ack_lat = 20;
    drive(0, 1, 24'h000400, 0);
    exp_q.push_back('{0, 24'h000400, 2'b11, 0});
    repeat (2) @(negedge MCLK);
    chk("pre_rst_req", 32'(bus.MEM_REQ), 1);
    #2 RESET_N = 0;
    #1;
    chk("mid_rst_req", 32'(bus.MEM_REQ), 0);
    chk("mid_rst_rom_q", 32'(bus.ROM_Q), 0);
    chk("mid_rst_busy", 32'(bus.BUSY), 0);
    bus.ROM_CE_N = 1;
    bus.ROM_OE_N = 1;
    @(negedge MCLK);
    RESET_N = 1;
    @(negedge MCLK);
    man_req++;
    repeat (3) @(negedge MCLK);
    chk("late_ack_rom_q", 32'(bus.ROM_Q), 0);
    chk("late_ack_req", 32'(bus.MEM_REQ), 0);
    chk("late_ack_busy", 32'(bus.BUSY), 0);

    // Repeated read of one word, then a byte write to it and a re-read.
    v = '{0, 1, 24'h002000, 0, 1, 16'h1234, 24'h002000, 2'b11, 0, 16'h1234};
    apply(v);
    v = '{0, 1, 24'h003000, 0, 1, 16'h5678, 24'h003000, 2'b11, 0, 16'h5678};
    apply(v);
`ifdef ROM_READ_CACHE_EN
    @(negedge MCLK);
    rsp_data = 16'h9999;
    drive(0, 1, 24'h003000, 0);
    @(negedge MCLK);
    chk("hit_no_req", 32'(bus.MEM_REQ), 0);
    chk("hit_rom_q", 32'(bus.ROM_Q), 16'h5678);
    idle();
    q3 = 16'h5678;
`else
    v = '{0, 1, 24'h003000, 0, 1, 16'h9999, 24'h003000, 2'b11, 0, 16'h9999};
    apply(v);
    q3 = 16'h9999;
`endif
    v = '{1, 0, 24'h003001, 16'h00AB, 0, 16'h0000, 24'h003000, 2'b10, 16'hABAB, q3};
    apply(v);
    v = '{0, 1, 24'h003000, 0, 2, 16'h4321, 24'h003000, 2'b11, 0, 16'h4321};
    apply(v);

    repeat (3) @(negedge MCLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
